// File: rtl/hazard_tuse_tracker_if.sv
// D-stage decode bundle into the hazard tracker and its stall/forwarding answer back to the datapath.
interface hazard_tuse_tracker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             d_valid;
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic [1:0]       d_tuse_rs;
  logic [1:0]       d_tuse_rt;
  logic             d_we;
  logic [4:0]       d_dst;
  logic [1:0]       d_tnew;
  logic             ext_stall;
  logic             stall;
  logic [1:0]       fwd_rs;
  logic [1:0]       fwd_rt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_dst, d_tnew, ext_stall,
    input  stall, fwd_rs, fwd_rt, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_dst, d_tnew, ext_stall,
    output stall, fwd_rs, fwd_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_tuse_tracker.sv
// Tnew/Tuse hazard tracker: shadows E/M/W GRF writers, raises stall and picks forwarding sources
// for the D-stage rs/rt reads.
module hazard_tuse_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hazard_tuse_tracker_if.slave  bus
);
  localparam int unsigned RW = 5;
  localparam int unsigned TW = 2;
  localparam int unsigned NS = 2;

  logic          e_v, m_v, w_v;
  logic [RW-1:0] e_dst, m_dst, w_dst;
  logic [TW-1:0] e_tnew, m_tnew;
  logic [CNT_W-1:0] cnt;

  logic [RW-1:0] src  [NS];
  logic [TW-1:0] tuse [NS];
  logic [1:0]    fwd  [NS];
  logic [NS-1:0] rd, e_hit, m_hit, w_hit, haz;
  logic          e_live, m_live, w_live;
  logic          stall;

  assign src[0]  = bus.d_rs;
  assign src[1]  = bus.d_rt;
  assign tuse[0] = bus.d_tuse_rs;
  assign tuse[1] = bus.d_tuse_rt;

  // Writes to $0 never create a dependency.
  assign e_live = e_v && (e_dst != '0);
  assign m_live = m_v && (m_dst != '0);
  assign w_live = w_v && (w_dst != '0);

  // Per source: hazard from any too-young E/M producer; forwarding from the nearest producer only.
  always_comb begin
    rd    = '0;
    e_hit = '0;
    m_hit = '0;
    w_hit = '0;
    haz   = '0;
    fwd[0] = 2'd0;
    fwd[1] = 2'd0;
    for (int s = 0; s < NS; s++) begin
      rd[s]    = bus.d_valid && (src[s] != '0) && (tuse[s] != 2'b11);
      e_hit[s] = rd[s] && e_live && (e_dst == src[s]);
      m_hit[s] = rd[s] && m_live && (m_dst == src[s]);
      w_hit[s] = rd[s] && w_live && (w_dst == src[s]);
      haz[s]   = (e_hit[s] && (e_tnew > tuse[s])) || (m_hit[s] && (m_tnew > tuse[s]));
      if (e_hit[s]) begin
        fwd[s] = (e_tnew == '0) ? 2'd1 : 2'd0;
      end else if (m_hit[s]) begin
        fwd[s] = (m_tnew == '0) ? 2'd2 : 2'd0;
      end else if (w_hit[s]) begin
        fwd[s] = 2'd3;
      end
    end
  end

  assign stall         = bus.ext_stall || (|haz);
  assign bus.stall     = stall;
  assign bus.fwd_rs    = fwd[0];
  assign bus.fwd_rt    = fwd[1];
  assign bus.stall_cnt = cnt;

  // Shadow pipeline advances every edge; a stalled D stage sends a bubble into E.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_v    <= 1'b0;
      e_dst  <= '0;
      e_tnew <= '0;
      m_v    <= 1'b0;
      m_dst  <= '0;
      m_tnew <= '0;
      w_v    <= 1'b0;
      w_dst  <= '0;
    end else begin
      w_v    <= m_v;
      w_dst  <= m_dst;
      m_v    <= e_v;
      m_dst  <= e_dst;
      m_tnew <= (e_tnew == '0) ? TW'(0) : e_tnew - TW'(1);
      if (stall) begin
        e_v    <= 1'b0;
        e_dst  <= '0;
        e_tnew <= '0;
      end else begin
        e_v    <= bus.d_valid && bus.d_we;
        e_dst  <= bus.d_dst;
        e_tnew <= bus.d_tnew;
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (stall && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule
